seq_ctrl: RTL and testbench
===========================

SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 SHALL have parameter PC_RESET, default 8'h00: PC value loaded at reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port run  input  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
REQ-005 SHALL have port rom_adrs  output  8  program ROM address, always equal to PC.
REQ-006 SHALL have port rom_rd  output  1  ROM read enable; ROM data is combinational and valid in the same cycle.
REQ-007 SHALL have port rom_dout  input  8  ROM read data.
REQ-008 SHALL have port mem_adrs  output  8  data memory / I/O address.
REQ-009 SHALL have port mem_rd  output  1  one-cycle read strobe; mem_rdata is valid the following cycle.
REQ-010 SHALL have port mem_wr  output  1  one-cycle write strobe.
REQ-011 SHALL have port mem_wdata  output  8  write data, always equal to GR.
REQ-012 SHALL have port mem_rdata  input  8  read data.
REQ-013 SHALL have ports pc, gr (output 8 each) and cf, busy, halt (output 1 each): architectural state and status.

Function
REQ-014 SHALL decode opcodes LDI=01, LD=02, ADDI=03, ADD=04, ST=05, JUMP=06; every instruction is 2 bytes: opcode, then operand.
REQ-015 SHALL implement states IDLE, FOP, FARG, MRD, EXE, HALT; the reset state is IDLE.
REQ-016 IDLE: if run=1, go to FOP; otherwise stay; busy=0.
REQ-017 FOP: rom_rd=1; IR<=rom_dout. For a legal opcode: PC<=PC+1, go to FARG. For an illegal opcode (00 or >06): PC is held, go to HALT.
REQ-018 FARG: rom_rd=1; ARG<=rom_dout; PC<=PC+1. For LD/ADD go to MRD; otherwise go to EXE.
REQ-019 MRD: mem_adrs=ARG, mem_rd=1 for exactly one cycle; go to EXE.
REQ-020 EXE actions:
  - LDI: GR<=ARG.
  - ADDI: {CF,GR}<=GR+ARG.
  - LD: GR<=mem_rdata.
  - ADD: {CF,GR}<=GR+mem_rdata.
  - ST: mem_adrs=ARG, mem_wr=1.
  - JUMP: PC<=ARG.
  Then go to FOP if run=1, else IDLE.
REQ-021 Latency SHALL be: LDI, ADDI, ST and JUMP take 3 cycles; LD and ADD take 4 cycles.
REQ-022 Addition SHALL be unsigned 8-bit, wrapping modulo 256, with carry-out into CF; CF is changed only by ADD and ADDI.
REQ-023 PC SHALL wrap from 8'hFF to 8'h00; a FARG fetch at 8'hFF reads the operand from 8'h00.
REQ-024 run=0 during FOP, FARG, MRD or EXE SHALL NOT abort the instruction; it completes, then the block enters IDLE.
REQ-025 HALT SHALL be absorbing until reset: halt=1, busy=0, and no ROM or memory strobes.
REQ-026 busy SHALL be 1 in FOP, FARG, MRD and EXE, and 0 otherwise.
REQ-027 mem_rd and mem_wr SHALL never be 1 in the same cycle.
REQ-028 rom_rd SHALL be 0 outside FOP and FARG; mem_adrs SHALL be 0 when neither memory strobe is active.

Reset
REQ-029 While rst_n=0, the following SHALL hold:
  - state=IDLE, pc=PC_RESET;
  - gr=0, cf=0, IR=0, ARG=0;
  - busy=0, halt=0;
  - rom_rd=0, mem_rd=0, mem_wr=0, mem_adrs=0, mem_wdata=0.
REQ-030 Reset asserted mid-instruction SHALL drop all strobes immediately, without waiting for clk; no partial write completes after reset assertion.
REQ-031 After rst_n rises, the first FOP SHALL begin on the first clk edge that sees run=1.

Structure
REQ-032 Opcode constants, the state encoding and the instruction byte width SHALL be defined in a shared package, ctrl_pkg.
REQ-033 The 8-bit adder with carry-out SHALL be a sub-module, add8c, instantiated once.
REQ-034 Next-state, decode and strobe logic SHALL be combinational from the registered state, IR and ARG; all architectural state is registered.

Verification
REQ-035 ROM = 01 05 03 03 05 20, run=1 from reset -> exactly one mem_wr pulse, with mem_adrs=20 and mem_wdata=08, in cycle 9; gr=08, cf=0.
REQ-036 GR=F0 and mem[21]=20, then ADD 21 -> mem_rd pulse at adrs 21 in cycle 3 of the instruction; in EXE gr=10, cf=1.
REQ-037 JUMP 08 at PC=12 -> the next FOP has rom_adrs=08; gr and cf are unchanged.
REQ-038 Opcode 00 at PC=0A -> halt=1 from the next cycle, pc stays 0A, no strobes for 20 cycles, and halt is cleared only by rst_n.
REQ-039 rst_n pulled low during EXE of ST -> mem_wr=0 before the next clk edge, pc=PC_RESET, state IDLE, busy=0.
REQ-040 run dropped during FARG of LD -> the LD completes (gr updated), the block then idles with busy=0; re-asserting run fetches from the updated PC.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the seq_ctrl instruction sequencer.
//   - BYTE_W      : instruction / data byte width
//   - byte_t      : one byte of program or data
//   - OP_*        : opcode values (every instruction is opcode byte + operand byte)
//   - state_t     : sequencer state encoding
//   - is_legal_op : true for the six defined opcodes
package ctrl_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    localparam byte_t OP_LDI  = 8'h01;
    localparam byte_t OP_LD   = 8'h02;
    localparam byte_t OP_ADDI = 8'h03;
    localparam byte_t OP_ADD  = 8'h04;
    localparam byte_t OP_ST   = 8'h05;
    localparam byte_t OP_JUMP = 8'h06;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FOP,
        S_FARG,
        S_MRD,
        S_EXE,
        S_HALT
    } state_t;

    function automatic logic is_legal_op(input byte_t op);
        return (op >= OP_LDI) && (op <= OP_JUMP);
    endfunction

endpackage

// File: rtl/add8c.sv
// add8c: 8-bit unsigned adder with carry-out.
//   a, b : addends
//   sum  : (a + b) mod 256
//   co   : carry out of bit 7
module add8c
    import ctrl_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    output logic [BYTE_W-1:0] sum,
    output logic              co
);

    assign {co, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: two-byte-instruction sequencer with one general register (GR)
// and a carry flag (CF).
//   clk, rst_n           : clock, asynchronous active-low reset
//   run                  : 1 = execute, 0 = stop at the next instruction boundary
//   rom_adrs/rom_rd      : program ROM address (= PC) and read enable
//   rom_dout             : combinational ROM data
//   mem_adrs             : data memory address (0 unless a strobe is active)
//   mem_rd/mem_wr        : one-cycle read / write strobes
//   mem_wdata/mem_rdata  : write data (= GR) / read data (valid cycle after mem_rd)
//   pc, gr, cf           : architectural state
//   busy, halt           : status (busy while an instruction is in flight)
module seq_ctrl
    import ctrl_pkg::*;
#(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic [7:0] rom_adrs,
    output logic       rom_rd,
    input  logic [7:0] rom_dout,
    output logic [7:0] mem_adrs,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic [7:0] pc,
    output logic [7:0] gr,
    output logic       cf,
    output logic       busy,
    output logic       halt
);

    state_t state_q, state_d;
    byte_t  pc_q, pc_d;
    byte_t  gr_q, gr_d;
    logic   cf_q, cf_d;
    byte_t  ir_q, ir_d;
    byte_t  arg_q, arg_d;

    byte_t  add_b;
    byte_t  add_sum;
    logic   add_co;

    // ADD takes its second operand from memory, ADDI from the immediate.
    assign add_b = (ir_q == OP_ADD) ? mem_rdata : arg_q;

    add8c u_add8c (
        .a   (gr_q),
        .b   (add_b),
        .sum (add_sum),
        .co  (add_co)
    );

    // Strobes decode from the registered state only, so the asynchronous
    // reset forcing state_q to S_IDLE drops them without waiting for clk.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RESET;
            gr_q    <= '0;
            cf_q    <= 1'b0;
            ir_q    <= '0;
            arg_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            gr_q    <= gr_d;
            cf_q    <= cf_d;
            ir_q    <= ir_d;
            arg_q   <= arg_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        gr_d     = gr_q;
        cf_d     = cf_q;
        ir_d     = ir_q;
        arg_d    = arg_q;
        rom_rd   = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_adrs = '0;
        busy     = 1'b0;
        halt     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FOP;
            end

            S_FOP: begin
                busy   = 1'b1;
                rom_rd = 1'b1;
                ir_d   = rom_dout;
                // An illegal opcode leaves PC pointing at the offending byte.
                if (is_legal_op(rom_dout)) begin
                    pc_d    = pc_q + 8'd1;
                    state_d = S_FARG;
                end else begin
                    state_d = S_HALT;
                end
            end

            S_FARG: begin
                busy   = 1'b1;
                rom_rd = 1'b1;
                arg_d  = rom_dout;
                pc_d   = pc_q + 8'd1;
                if (ir_q == OP_LD || ir_q == OP_ADD) state_d = S_MRD;
                else                                 state_d = S_EXE;
            end

            S_MRD: begin
                busy     = 1'b1;
                mem_rd   = 1'b1;
                mem_adrs = arg_q;
                state_d  = S_EXE;
            end

            S_EXE: begin
                busy = 1'b1;
                case (ir_q)
                    OP_LDI:         gr_d = arg_q;
                    OP_LD:          gr_d = mem_rdata;
                    OP_ADDI,
                    OP_ADD:         {cf_d, gr_d} = {add_co, add_sum};
                    OP_ST: begin
                        mem_wr   = 1'b1;
                        mem_adrs = arg_q;
                    end
                    OP_JUMP:        pc_d = arg_q;
                    default:        ;
                endcase
                state_d = run ? S_FOP : S_IDLE;
            end

            S_HALT: begin
                halt = 1'b1;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign rom_adrs  = pc_q;
    assign mem_wdata = gr_q;
    assign pc        = pc_q;
    assign gr        = gr_q;
    assign cf        = cf_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: directed self-checking bench for seq_ctrl with a behavioural
// ROM (combinational) and data memory (registered read, one-cycle latency).
module tb_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [7:0] rom_adrs;
    logic       rom_rd;
    logic [7:0] rom_dout;
    logic [7:0] mem_adrs;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] pc;
    logic [7:0] gr;
    logic       cf;
    logic       busy;
    logic       halt;

    logic [7:0] rom [256];
    logic [7:0] mem [256];
    logic       tb_we = 1'b0;
    logic [7:0] tb_wa = 8'h00;
    logic [7:0] tb_wd = 8'h00;
    int         wr_total = 0;

    int n_checks = 0;
    int n_fail   = 0;

    seq_ctrl #(.PC_RESET(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .rom_adrs  (rom_adrs),
        .rom_rd    (rom_rd),
        .rom_dout  (rom_dout),
        .mem_adrs  (mem_adrs),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pc        (pc),
        .gr        (gr),
        .cf        (cf),
        .busy      (busy),
        .halt      (halt)
    );

    always #5 clk = ~clk;

    assign rom_dout = rom[rom_adrs];

    always @(posedge clk) begin
        if (tb_we) mem[tb_wa] <= tb_wd;
        if (mem_rd) mem_rdata <= mem[mem_adrs];
        if (mem_wr) begin
            mem[mem_adrs] <= mem_wdata;
            wr_total      <= wr_total + 1;
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        tb_wa = a;
        tb_wd = d;
        tb_we = 1'b1;
        @(posedge clk);
        #1;
        tb_we = 1'b0;
    endtask

    task automatic enter_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic leave_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int wr_cnt, wr_cyc, wr0, strobes, pc_moves, halt_drops;
        logic [7:0] wr_a, wr_d;

        // ---------------- A: store program, reset values ----------------
        run = 1'b1;
        clear_rom();
        rom[0] = 8'h01; rom[1] = 8'h05; rom[2] = 8'h03;
        rom[3] = 8'h03; rom[4] = 8'h05; rom[5] = 8'h20;
        enter_reset();
        check("rst_pc",    pc,        8'h00);
        check("rst_gr",    gr,        8'h00);
        check("rst_cf",    cf,        1'b0);
        check("rst_busy",  busy,      1'b0);
        check("rst_halt",  halt,      1'b0);
        check("rst_strb",  {rom_rd, mem_rd, mem_wr}, 3'b000);
        check("rst_madr",  mem_adrs,  8'h00);
        check("rst_wdat",  mem_wdata, 8'h00);
        leave_reset();
        wr_cnt = 0; wr_cyc = 0; wr_a = 8'h00; wr_d = 8'h00;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) begin
                check("a_fop_rd",  rom_rd,   1'b1);
                check("a_fop_bsy", busy,     1'b1);
                check("a_fop_adr", rom_adrs, 8'h00);
            end
            if (mem_wr) begin
                wr_cnt++;
                wr_cyc = c;
                wr_a   = mem_adrs;
                wr_d   = mem_wdata;
            end
        end
        check("a_wr_cnt",  wr_cnt[15:0], 16'd1);
        check("a_wr_cyc",  wr_cyc[15:0], 16'd9);
        check("a_wr_adr",  wr_a,  8'h20);
        check("a_wr_dat",  wr_d,  8'h08);
        check("a_gr",      gr,    8'h08);
        check("a_cf",      cf,    1'b0);
        check("a_halt",    halt,  1'b1);
        check("a_halt_pc", pc,    8'h06);

        // ---------------- B: ADD carry, JUMP, illegal-opcode halt ----------------
        enter_reset();
        clear_rom();
        rom[8'h00] = 8'h01; rom[8'h01] = 8'hF0;   // LDI F0
        rom[8'h02] = 8'h04; rom[8'h03] = 8'h21;   // ADD [21]
        rom[8'h04] = 8'h06; rom[8'h05] = 8'h12;   // JUMP 12
        rom[8'h12] = 8'h06; rom[8'h13] = 8'h08;   // JUMP 08
        rom[8'h08] = 8'h03; rom[8'h09] = 8'h05;   // ADDI 05
        rom[8'h0A] = 8'h00;                       // illegal
        poke(8'h21, 8'h20);
        leave_reset();
        for (int c = 1; c <= 18; c++) begin
            tick();
            case (c)
                5:  check("b_farg_nord", mem_rd, 1'b0);
                6: begin
                    check("b_mrd",     mem_rd,   1'b1);
                    check("b_mrd_adr", mem_adrs, 8'h21);
                    check("b_mrd_nwr", mem_wr,   1'b0);
                end
                7:  check("b_exe_nord", mem_rd, 1'b0);
                8: begin
                    check("b_add_gr", gr, 8'h10);
                    check("b_add_cf", cf, 1'b1);
                end
                11: check("b_jmp1_adr", rom_adrs, 8'h12);
                14: begin
                    check("b_jmp2_adr", rom_adrs, 8'h08);
                    check("b_jmp_gr",   gr,       8'h10);
                    check("b_jmp_cf",   cf,       1'b1);
                end
                17: begin
                    check("b_addi_gr", gr, 8'h15);
                    check("b_addi_cf", cf, 1'b0);
                end
                18: begin
                    check("b_halt",     halt, 1'b1);
                    check("b_halt_bsy", busy, 1'b0);
                    check("b_halt_pc",  pc,   8'h0A);
                end
                default: ;
            endcase
        end
        strobes = 0; pc_moves = 0; halt_drops = 0;
        for (int c = 0; c < 20; c++) begin
            run = c[0];
            tick();
            if (rom_rd || mem_rd || mem_wr || busy) strobes++;
            if (pc != 8'h0A) pc_moves++;
            if (!halt) halt_drops++;
        end
        run = 1'b1;
        check("b_halt_strb", strobes[15:0],    16'd0);
        check("b_halt_pcmv", pc_moves[15:0],   16'd0);
        check("b_halt_keep", halt_drops[15:0], 16'd0);

        // ---------------- C: reset during EXE of ST ----------------
        enter_reset();
        check("c_rst_clrs_halt", halt, 1'b0);
        clear_rom();
        rom[0] = 8'h01; rom[1] = 8'hAA; rom[2] = 8'h05; rom[3] = 8'h40;
        leave_reset();
        for (int c = 1; c <= 6; c++) tick();
        check("c_st_wr",  mem_wr,    1'b1);
        check("c_st_adr", mem_adrs,  8'h40);
        check("c_st_dat", mem_wdata, 8'hAA);
        wr0 = wr_total;
        #2 rst_n = 1'b0;
        #1;
        check("c_async_wr",   mem_wr,   1'b0);
        check("c_async_adr",  mem_adrs, 8'h00);
        check("c_async_pc",   pc,       8'h00);
        check("c_async_busy", busy,     1'b0);
        check("c_async_gr",   gr,       8'h00);
        tick();
        check("c_no_write", wr_total[15:0], wr0[15:0]);
        check("c_idle_rom", rom_rd, 1'b0);

        // ---------------- D: run dropped during FARG of LD ----------------
        enter_reset();
        clear_rom();
        rom[0] = 8'h02; rom[1] = 8'h21;   // LD [21]
        rom[2] = 8'h01; rom[3] = 8'h33;   // LDI 33
        poke(8'h21, 8'h5A);
        leave_reset();
        tick();                  // FOP
        tick();                  // FARG
        run = 1'b0;
        tick();
        check("d_mrd_busy", busy, 1'b1);
        tick();
        check("d_exe_busy", busy, 1'b1);
        tick();
        check("d_idle_busy", busy, 1'b0);
        check("d_ld_gr",     gr,   8'h5A);
        check("d_idle_pc",   pc,   8'h02);
        tick();
        tick();
        check("d_still_idle", {busy, rom_rd}, 2'b00);
        run = 1'b1;
        tick();
        check("d_refetch_adr", rom_adrs, 8'h02);
        check("d_refetch_rd",  rom_rd,   1'b1);
        tick();
        tick();
        tick();
        check("d_ldi_gr", gr, 8'h33);

        // ---------------- E: PC wrap at FF, opcode > 06 halts ----------------
        enter_reset();
        clear_rom();
        rom[8'h00] = 8'h06; rom[8'h01] = 8'hFF;   // JUMP FF; FF is also illegal
        rom[8'hFF] = 8'h01;                       // LDI, operand wraps to 00
        leave_reset();
        for (int c = 1; c <= 8; c++) begin
            tick();
            case (c)
                4: check("e_fop_ff",   rom_adrs, 8'hFF);
                5: check("e_farg_wrap", rom_adrs, 8'h00);
                7: begin
                    check("e_gr", gr, 8'h06);
                    check("e_pc", pc, 8'h01);
                end
                8: begin
                    check("e_halt",    halt, 1'b1);
                    check("e_halt_pc", pc,   8'h01);
                    check("e_cf",      cf,   1'b0);
                end
                default: ;
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
